// File: rtl/io_timer.sv
// 16-bit programmable interval timer on the Riley0 I/O space: prescaled down-counter,
// auto-reload or one-shot, expiry flag with level irq, and coherent counter readback.
module io_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       CLOCK_IN,
  input  logic       RESET,
  input  logic [2:0] address,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       write_enable,
  input  logic       io_sel,
  output logic       irq
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  localparam logic [2:0] A_CTRL    = 3'd0;
  localparam logic [2:0] A_STATUS  = 3'd1;
  localparam logic [2:0] A_LATCH_L = 3'd2;
  localparam logic [2:0] A_LATCH_H = 3'd3;
  localparam logic [2:0] A_COUNT_L = 3'd4;
  localparam logic [2:0] A_HOLD_H  = 3'd5;

  logic [2:0]    ctrl;       // {IE, RELOAD, EN}
  logic          exp_flag;
  logic [7:0]    latch_lo;
  logic [7:0]    latch_hi;
  logic [15:0]   counter;
  logic [7:0]    hold;
  logic [PW-1:0] prescaler;

  logic wr, rd, wr_ctrl, wr_status, wr_latch_lo, wr_latch_hi;
  logic en, reload, tick, expire;

  assign wr          = io_sel & write_enable;
  assign rd          = io_sel & ~write_enable;
  assign wr_ctrl     = wr && (address == A_CTRL);
  assign wr_status   = wr && (address == A_STATUS);
  assign wr_latch_lo = wr && (address == A_LATCH_L);
  assign wr_latch_hi = wr && (address == A_LATCH_H);

  assign en     = ctrl[0];
  assign reload = ctrl[1];
  assign tick   = en && (prescaler == PS_LAST);
  // A LATCH_HI write pre-empts the expiry that would otherwise happen this edge.
  assign expire = !wr_latch_hi && tick && (counter == 16'h0000);

  // Both flops, so irq never follows the bus combinationally.
  assign irq = exp_flag & ctrl[2];

  // NOTE: every sequential block uses non-blocking (<=) so all flops see pre-edge values.
  always_ff @(posedge CLOCK_IN or negedge RESET) begin
    if (!RESET) begin
      prescaler <= '0;
    end else if (wr_ctrl || wr_latch_hi || !en || tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // A CTRL write overrides the one-shot auto-disable in the same cycle.
  always_ff @(posedge CLOCK_IN or negedge RESET) begin
    if (!RESET) begin
      ctrl <= 3'b000;
    end else if (wr_ctrl) begin
      ctrl <= data_in[2:0];
    end else if (expire && !reload) begin
      ctrl[0] <= 1'b0;
    end
  end

  // Expiry set takes precedence over a simultaneous write-1-to-clear.
  always_ff @(posedge CLOCK_IN or negedge RESET) begin
    if (!RESET) begin
      exp_flag <= 1'b0;
    end else if (wr_latch_hi) begin
      exp_flag <= 1'b0;
    end else if (expire) begin
      exp_flag <= 1'b1;
    end else if (wr_status && data_in[0]) begin
      exp_flag <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_IN or negedge RESET) begin
    if (!RESET) begin
      latch_lo <= 8'hFF;
      latch_hi <= 8'hFF;
    end else begin
      if (wr_latch_lo) latch_lo <= data_in;
      if (wr_latch_hi) latch_hi <= data_in;
    end
  end

  always_ff @(posedge CLOCK_IN or negedge RESET) begin
    if (!RESET) begin
      counter <= 16'hFFFF;
    end else if (wr_latch_hi) begin
      counter <= {data_in, latch_lo};
    end else if (tick) begin
      if (counter != 16'h0000) begin
        counter <= counter - 16'd1;
      end else if (reload) begin
        counter <= {latch_hi, latch_lo};
      end
    end
  end

  // Reading COUNT_LO freezes the high byte so a later COUNT_HI_HOLD read is coherent.
  always_ff @(posedge CLOCK_IN or negedge RESET) begin
    if (!RESET) begin
      hold     <= 8'h00;
      data_out <= 8'h00;
    end else if (rd) begin
      if (address == A_COUNT_L) hold <= counter[15:8];
      case (address)
        A_CTRL:    data_out <= {5'b00000, ctrl};
        A_STATUS:  data_out <= {7'b0000000, exp_flag};
        A_LATCH_L: data_out <= latch_lo;
        A_LATCH_H: data_out <= latch_hi;
        A_COUNT_L: data_out <= counter[7:0];
        A_HOLD_H:  data_out <= hold;
        default:   data_out <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_io_timer.sv
// Directed bench for io_timer: one instance with PRESCALE=1 and one with PRESCALE=4
// share the bus; each has its own select, read data and irq.
module tb_io_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] address;
  logic [7:0] data_in;
  logic       write_enable;
  logic       sel1, sel4;
  logic [7:0] dout1, dout4;
  logic       irq1, irq4;
  logic       use4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_timer #(.PRESCALE(1)) dut_p1 (
    .CLOCK_IN(clk), .RESET(rst_n), .address(address), .data_in(data_in),
    .data_out(dout1), .write_enable(write_enable), .io_sel(sel1), .irq(irq1)
  );

  io_timer #(.PRESCALE(4)) dut_p4 (
    .CLOCK_IN(clk), .RESET(rst_n), .address(address), .data_in(data_in),
    .data_out(dout4), .write_enable(write_enable), .io_sel(sel4), .irq(irq4)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] dout();
    return use4 ? dout4 : dout1;
  endfunction

  function automatic logic cur_irq();
    return use4 ? irq4 : irq1;
  endfunction

  // All bus tasks start and end on a falling edge; the rising edge in between is the access.
  task automatic bus_idle();
    sel1 = 1'b0;
    sel4 = 1'b0;
    write_enable = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    address = a;
    data_in = d;
    write_enable = 1'b1;
    sel1 = !use4;
    sel4 = use4;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read_begin(input logic [2:0] a);
    address = a;
    write_enable = 1'b0;
    sel1 = !use4;
    sel4 = use4;
  endtask

  task automatic bus_read(input string tag, input logic [2:0] a, input logic [7:0] exp);
    bus_read_begin(a);
    @(negedge clk);
    check(tag, 16'(dout()), 16'(exp));
    bus_idle();
  endtask

  logic [7:0] rst_exp [8];

  initial begin
    rst_exp = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    use4 = 1'b0;
    address = '0;
    data_in = '0;
    bus_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("por_irq", 16'(irq1), 16'h0);
    check("por_dout", 16'(dout1), 16'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Auto-reload, latch=0003: expiries on the 4th, 8th and 12th edge after the CTRL write
    bus_write(3'd2, 8'h03);
    bus_write(3'd3, 8'h00);
    bus_write(3'd0, 8'h07);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("ar_irq_e%0d", k), 16'(irq1), 16'(k == 4));
    end
    bus_read_begin(3'd4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("ar_cnt_%0d", k), 16'(dout1), 16'(3 - k));
    end
    bus_idle();
    bus_write(3'd1, 8'h01);
    check("ar_clear_irq", 16'(irq1), 16'h0);
    for (int k = 10; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("ar_irq_e%0d", k), 16'(irq1), 16'(k == 12));
    end

    // Clear racing an expiry: latch=0001, the STATUS write lands on the expiry edge
    bus_write(3'd0, 8'h00);
    bus_write(3'd1, 8'h01);
    bus_write(3'd2, 8'h01);
    bus_write(3'd3, 8'h00);
    bus_write(3'd0, 8'h07);
    @(negedge clk);
    check("race_pre_irq", 16'(irq1), 16'h0);
    bus_write(3'd1, 8'h01);
    check("race_irq", 16'(irq1), 16'h1);
    bus_read("race_status", 3'd1, 8'h01);
    bus_write(3'd0, 8'h03);
    check("ie_off_irq", 16'(irq1), 16'h0);
    bus_read("ie_off_status", 3'd1, 8'h01);

    // One-shot, latch=0002: expiry on the 3rd edge, EN self-clears
    bus_write(3'd0, 8'h00);
    bus_write(3'd1, 8'h01);
    bus_write(3'd2, 8'h02);
    bus_write(3'd3, 8'h00);
    bus_write(3'd0, 8'h05);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("os_irq_e%0d", k), 16'(irq1), 16'(k == 3));
    end
    bus_read("os_ctrl", 3'd0, 8'h04);
    bus_read("os_cnt_lo", 3'd4, 8'h00);
    bus_read("os_cnt_hi", 3'd5, 8'h00);
    bus_write(3'd1, 8'h01);
    repeat (5) @(negedge clk);
    check("os_no_rearm_irq", 16'(irq1), 16'h0);
    bus_read("os_no_rearm_status", 3'd1, 8'h00);
    bus_write(3'd2, 8'h55);
    bus_read("latch_lo_no_load", 3'd4, 8'h00);
    bus_read("latch_lo_readback", 3'd2, 8'h55);

    // Coherent read: snapshot at counter=0100, high byte read when counter is already 00FE
    bus_write(3'd0, 8'h00);
    bus_write(3'd1, 8'h01);
    bus_write(3'd2, 8'h00);
    bus_write(3'd3, 8'h01);
    bus_write(3'd0, 8'h03);
    bus_read("coh_lo", 3'd4, 8'h00);
    @(negedge clk);
    bus_read("coh_hi", 3'd5, 8'h01);

    // Asynchronous reset while running
    rst_n = 1'b0;
    #1;
    check("rst_irq", 16'(irq1), 16'h0);
    check("rst_dout", 16'(dout1), 16'h00);
    @(negedge clk);
    rst_n = 1'b1;
    // Hold is read before COUNT_LO so the snapshot does not overwrite its reset value
    for (int i = 0; i < 8; i++) begin
      automatic logic [2:0] a = (i == 4) ? 3'd5 : (i == 5) ? 3'd4 : 3'(i);
      bus_read($sformatf("rst_rd_%0d", a), a, rst_exp[a]);
    end
    check("rst_irq_after", 16'(irq1), 16'h0);

    // Prescaler=4, latch=0001: EXP set on the 8th edge, seen by the read on the 9th
    use4 = 1'b1;
    bus_write(3'd2, 8'h01);
    bus_write(3'd3, 8'h00);
    bus_write(3'd0, 8'h03);
    bus_read_begin(3'd1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("ps_status_e%0d", k), 16'(dout4), 16'(k == 9));
    end
    bus_idle();
    bus_write(3'd3, 8'h00);
    bus_read_begin(3'd1);
    for (int k = 11; k <= 19; k++) begin
      @(negedge clk);
      check($sformatf("ps_restart_e%0d", k), 16'(dout4), 16'(k == 19));
    end
    bus_idle();
    check("ps_irq_ie_off", 16'(cur_irq()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_timer.md
Name: io_timer

Overview:
Memory-mapped 16-bit programmable interval timer on the Riley0 I/O space. It is selected by io_sel from the address decoder, sits on the 65C02 address and data buses beside the SRAM, and drives the CPU irq input. It provides the system periodic tick (auto-reload) and one-shot delays, with coherent 16-bit counter reads.

Parameters:
PRESCALE, 1, CPU clock cycles per counter tick; legal range 1..65536; prescaler width is clog2(PRESCALE), minimum 1 bit.

Ports:
CLOCK_IN  input  1  system clock; all state updates on the rising edge
RESET  input  1  asynchronous, active-low reset
address  input  3  register select, driven from CPU address bits [2:0]
data_in  input  8  write data from the CPU data-out bus
data_out  output  8  registered read data to the CPU data-in bus
write_enable  input  1  CPU WE; 1 = write cycle, 0 = read cycle
io_sel  input  1  chip select from the address decoder, active-high
irq  output  1  interrupt request to the CPU, active-high, level

Behaviour:
- Register map:
  - 0 CTRL, R/W: bit0 EN, bit1 RELOAD, bit2 IE; bits 7:3 read 0.
  - 1 STATUS: bit0 EXP, write-1-to-clear; bits 7:1 read 0, writes ignored.
  - 2 LATCH_LO, R/W.
  - 3 LATCH_HI, R/W; a write also loads the counter.
  - 4 COUNT_LO, read-only; a read snapshots counter[15:8] into the hold register.
  - 5 COUNT_HI_HOLD, read-only; returns the snapshot.
  - 6 and 7 read 00; writes ignored.
- Write: io_sel=1 and write_enable=1 on a rising edge. The register updates at that edge.
- Read: io_sel=1 and write_enable=0. data_out is loaded at that edge, so data is valid in the next cycle. data_out holds its value on all other cycles. Reads have no side effects except the COUNT_LO snapshot.
- Reset (RESET low, asynchronous):
  - CTRL=00, EXP=0.
  - latch=FFFF, counter=FFFF, hold=00.
  - prescaler=0, data_out=00, irq=0.
- Prescaler:
  - Counts 0..PRESCALE-1 while EN=1.
  - tick is asserted when prescaler==PRESCALE-1, then the prescaler wraps to 0.
  - The prescaler is held at 0 while EN=0 and cleared on any CTRL write.
- Counter, at each edge, in priority order:
  1. LATCH_HI write: counter <= {data_in, latch_lo}, EXP <= 0, prescaler <= 0. No expiry is evaluated that cycle.
  2. Else, EN=1, tick=1 and counter!=0: counter decrements by 1.
  3. Else, EN=1, tick=1 and counter==0 (expiry): EXP <= 1.
     - RELOAD=1: counter <= latch.
     - RELOAD=0: counter stays 0 and EN <= 0 (one-shot).
- Period: latch+1 ticks in auto-reload mode. Latch=0 with PRESCALE=1 expires every cycle.
- An EN 0->1 write starts decrementing on the first tick after that write edge.
- Simultaneous events:
  - STATUS write-1-to-clear in the same cycle as an expiry: the set wins and EXP stays 1.
  - CTRL write in the same cycle as a one-shot expiry: the written EN value wins; EXP is still set.
- LATCH_LO write does not affect the counter.
- irq = EXP & IE, taken directly from flops, no combinational path from bus inputs. Clearing IE drops irq without clearing EXP.
- Reset mid-count aborts immediately to the reset values; no spurious irq.

Test Plan:
- Reset and readback:
  - Stimulus: assert RESET low mid-count, release, then read addresses 0..7.
  - Required: data_out = 00,00,FF,FF,FF,00,00,00 respectively, one cycle after each read; irq=0.
- Auto-reload, PRESCALE=1:
  - Stimulus: write LATCH_LO=03, LATCH_HI=00, CTRL=07.
  - Required: EXP and irq rise on the 4th edge after the CTRL write, then every 4 cycles. A COUNT_LO read sequence cycles 03,02,01,00.
- One-shot:
  - Stimulus: latch=0002, CTRL=05.
  - Required: irq rises on the 3rd edge. CTRL then reads 04 and the counter stays 0000 with no further expiries.
- Clear and race:
  - Stimulus: write STATUS=01 on a non-expiry cycle; then write STATUS=01 on the exact expiry edge (latch=0001, RELOAD=1).
  - Required: first write clears EXP and irq; second leaves EXP=1.
- Coherent read:
  - Stimulus: latch=0100, PRESCALE=1, running; read COUNT_LO when the counter is 0100, then COUNT_HI_HOLD two cycles later.
  - Required: reads return 00 then 01, even though the counter is already 00FE.
- Prescaler:
  - Stimulus: PRESCALE=4, latch=0001, CTRL=03.
  - Required: EXP rises 8 cycles after the CTRL write; a LATCH_HI write mid-count reloads the counter, clears EXP and restarts the prescaler.
